fft_core_param: RTL and testbench
=================================

FFT_CORE_PARAM -- requirements
Module: fft_core_param

Interface
REQ-001 Parameter: LOG2N, default 3, log2 of transform length N (N = 2^LOG2N, legal 2..10).
REQ-002 Parameter: DW, default 16, signed two's-complement width of each real/imag sample.
REQ-003 Parameter: TW, default 16, signed twiddle width, format Q1.(TW-1).
REQ-004 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: scale_en  in  1  per-stage divide-by-2 enable, sampled on first accepted input sample.
REQ-007 Port: in_valid  in  1  input sample valid.
REQ-008 Port: in_ready  out  1  core accepts input sample.
REQ-009 Port: in_re / in_im  in  DW each  input sample real / imaginary.
REQ-010 Port: tw_addr  out  LOG2N-1  twiddle index k to external ROM pair.
REQ-011 Port: tw_cos / tw_sin  in  TW each  cos(2πk/N), sin(2πk/N); valid exactly 1 cycle after tw_addr.
REQ-012 Port: out_valid  out  1  output bin valid.
REQ-013 Port: out_ready  in  1  downstream accepts output bin.
REQ-014 Port: out_re / out_im  out  DW each  output bin real / imaginary.
REQ-015 Port: out_index  out  LOG2N  bin number of current output.
REQ-016 Port: out_last  out  1  high with bin N-1.
REQ-017 Port: busy  out  1  high in LOAD, CALC, UNLOAD.

Function
REQ-018 FSM states IDLE, LOAD, CALC, UNLOAD; IDLE->LOAD on first in handshake; LOAD->CALC after Nth handshake; CALC->UNLOAD after last butterfly write; UNLOAD->IDLE after out_last handshake.
REQ-019 in_ready = 1 in IDLE and LOAD, 0 otherwise; handshake = in_valid & in_ready.
REQ-020 Sample n stored at bit-reversed address of n in internal N x 2DW register memory; output natural order.
REQ-021 CALC: in-place radix-2 DIT, stages s = 0..LOG2N-1, butterflies b = 0..N/2-1 per stage, ascending.
REQ-022 Addressing: half = 2^s; j = b mod half; a = (b>>s)*2*half + j; bi = a+half; k = j << (LOG2N-1-s).
REQ-023 Each butterfly exactly 4 cycles: C0 drive tw_addr, read A,B; C1 register tw_cos/tw_sin; C2 register complex product t; C3 add/scale/saturate, write A', B'.
REQ-024 Twiddle w = cos - j·sin; t_re = Br·c + Bi·s, t_im = Bi·c - Br·s; each rounded: (p + 2^(TW-2)) >>> (TW-1).
REQ-025 A' = A + t, B' = A - t computed at DW+2 bits; if scale_en latched 1, arithmetic shift right 1 (floor); then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-026 CALC lasts exactly 2·N·LOG2N cycles; first out_valid asserted 2·N·LOG2N+1 cycles after last input handshake.
REQ-027 UNLOAD: out_valid high, out_index 0..N-1; out_re/out_im/out_index/out_last held stable while out_valid & !out_ready; advance one bin per handshake.
REQ-028 in_valid ignored outside IDLE/LOAD; scale_en changes after latch have no effect until next frame.
REQ-029 tw_addr = 0 outside CALC.
REQ-030 IDLE after UNLOAD accepts new frame in the cycle following out_last handshake (no back-to-back overlap).

Reset
REQ-031 rst high at clock edge: state IDLE, all counters 0, in_ready 1 on next cycle, out_valid 0, out_last 0, out_index 0, out_re/out_im 0, busy 0, tw_addr 0, scale latch 1.
REQ-032 rst mid-LOAD, CALC or UNLOAD aborts frame; partial data discarded, no output emitted; memory contents unspecified.

Verification
REQ-033 LOG2N=3, DW=TW=16, scale_en=1, x[0]=1000+0j, others 0 -> all 8 bins 125+0j exactly, out_last on bin 7.
REQ-034 scale_en=1, all x = 800+0j -> X[0] = 800±1, X[1..7] = 0±1; first out_valid 49 cycles after last input handshake.
REQ-035 scale_en=1, x[n] = +800,-800 alternating -> X[4] = 800±1, all others 0±1; tw_addr sequence checked against REQ-022.
REQ-036 scale_en=0, all x = 32767 -> X[0] = 32767 (saturated), others within ±2; no wrap to negative.
REQ-037 out_ready random 30% duty in UNLOAD -> outputs stable while stalled, 8 handshakes, indices 0..7 in order, then in_ready=1.
REQ-038 rst asserted at CALC cycle 20 -> next cycle out_valid=0, busy=0, in_ready=1; following impulse frame yields REQ-033 result.

Source files
------------

// File: rtl/fft_core_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_core_param_if
//  Brief    : Sample-in / twiddle-ROM / bin-out bundle for fft_core_param.
//  Revision : 1.0  initial release
// ============================================================================
interface fft_core_param_if #(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int TW    = 16
);
    logic                    scale_en;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_re;
    logic signed [DW-1:0]    in_im;
    logic [LOG2N-2:0]        tw_addr;
    logic signed [TW-1:0]    tw_cos;
    logic signed [TW-1:0]    tw_sin;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;
    logic [LOG2N-1:0]        out_index;
    logic                    out_last;
    logic                    busy;

    modport master (
        output scale_en, in_valid, in_re, in_im, tw_cos, tw_sin, out_ready,
        input  in_ready, tw_addr, out_valid, out_re, out_im, out_index, out_last, busy
    );

    modport slave (
        input  scale_en, in_valid, in_re, in_im, tw_cos, tw_sin, out_ready,
        output in_ready, tw_addr, out_valid, out_re, out_im, out_index, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/fft_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : fft_core_param
//  Brief    : In-place radix-2 DIT FFT, one 4-cycle butterfly at a time.
//  Revision : 1.0  initial release
// ============================================================================
module fft_core_param #(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int TW    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fft_core_param_if.slave   bus
);
    localparam int N  = 1 << LOG2N;
    localparam int BW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam int PW = DW + TW + 1;

    localparam logic [LOG2N-1:0]      CNT_LAST   = '1;
    localparam logic [BW-1:0]         BF_LAST    = '1;
    localparam logic [SW-1:0]         LAST_STAGE = SW'(LOG2N - 1);
    localparam logic signed [PW-1:0]  RND    = $signed({{(PW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}});
    localparam logic signed [DW+1:0]  SAT_HI = $signed({3'b000, {(DW-1){1'b1}}});
    localparam logic signed [DW+1:0]  SAT_LO = $signed({3'b111, {(DW-1){1'b0}}});

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CALC   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t                 state;
    logic [LOG2N-1:0]       cnt;
    logic [BW-1:0]          bf;
    logic [SW-1:0]          stage;
    logic [1:0]             phase;
    logic                   scale;

    logic signed [DW-1:0]   mem_re [N];
    logic signed [DW-1:0]   mem_im [N];
    logic signed [DW-1:0]   a_re, a_im, b_re, b_im;
    logic signed [TW-1:0]   c_reg, s_reg;
    logic signed [DW+1:0]   t_re, t_im;

    logic [LOG2N-1:0]       bf_ext, half, jj, addr_a, addr_b;
    logic [BW-1:0]          tw_k;
    logic signed [PW-1:0]   bre_x, bim_x, cos_x, sin_x, prod_re, prod_im;
    logic signed [DW+1:0]   ax_re, ax_im;
    logic signed [DW-1:0]   new_a_re, new_a_im, new_b_re, new_b_im;
    logic                   hs_in, hs_out;
    logic                   unused_round;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Optional floor halving, then clamp into the DW-bit output range.
    function automatic logic signed [DW-1:0] scale_sat(input logic signed [DW+1:0] v, input logic sc);
        logic signed [DW+1:0] s;
        logic signed [DW-1:0] r;
        s = sc ? (v >>> 1) : v;
        if (s > SAT_HI)      r = SAT_HI[DW-1:0];
        else if (s < SAT_LO) r = SAT_LO[DW-1:0];
        else                 r = s[DW-1:0];
        return r;
    endfunction

    always_comb begin
        bf_ext = {1'b0, bf};
        half   = {{(LOG2N-1){1'b0}}, 1'b1} << stage;
        jj     = bf_ext & (half - 1'b1);
        addr_a = (((bf_ext >> stage) << stage) << 1) | jj;
        addr_b = addr_a | half;
        tw_k   = BW'(jj << (LAST_STAGE - stage));
    end

    // w = cos - j*sin, so t = B * w; products widened so nothing truncates before rounding.
    always_comb begin
        bre_x    = $signed({{(TW+1){b_re[DW-1]}}, b_re});
        bim_x    = $signed({{(TW+1){b_im[DW-1]}}, b_im});
        cos_x    = $signed({{(DW+1){c_reg[TW-1]}}, c_reg});
        sin_x    = $signed({{(DW+1){s_reg[TW-1]}}, s_reg});
        prod_re  = bre_x * cos_x + bim_x * sin_x + RND;
        prod_im  = bim_x * cos_x - bre_x * sin_x + RND;
        ax_re    = $signed({{2{a_re[DW-1]}}, a_re});
        ax_im    = $signed({{2{a_im[DW-1]}}, a_im});
        new_a_re = scale_sat(ax_re + t_re, scale);
        new_a_im = scale_sat(ax_im + t_im, scale);
        new_b_re = scale_sat(ax_re - t_re, scale);
        new_b_im = scale_sat(ax_im - t_im, scale);
        unused_round = ^{prod_re[TW-2:0], prod_im[TW-2:0]};
    end

    assign hs_in  = bus.in_valid & bus.in_ready;
    assign hs_out = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bf            <= '0;
            stage         <= '0;
            phase         <= '0;
            scale         <= 1'b1;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            if (hs_in) begin
                mem_re[bitrev(cnt)] <= bus.in_re;
                mem_im[bitrev(cnt)] <= bus.in_im;
                cnt                 <= cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hs_in) begin
                        scale    <= bus.scale_en;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs_in && cnt == CNT_LAST) begin
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    phase <= phase + 1'b1;
                    case (phase)
                        2'd0: begin
                            a_re <= mem_re[addr_a];
                            a_im <= mem_im[addr_a];
                            b_re <= mem_re[addr_b];
                            b_im <= mem_im[addr_b];
                        end
                        2'd1: begin
                            c_reg <= bus.tw_cos;
                            s_reg <= bus.tw_sin;
                        end
                        2'd2: begin
                            t_re <= prod_re[PW-1:TW-1];
                            t_im <= prod_im[PW-1:TW-1];
                        end
                        default: begin
                            mem_re[addr_a] <= new_a_re;
                            mem_im[addr_a] <= new_a_im;
                            mem_re[addr_b] <= new_b_re;
                            mem_im[addr_b] <= new_b_im;
                            if (bf == BF_LAST) begin
                                bf <= '0;
                                if (stage == LAST_STAGE) begin
                                    stage         <= '0;
                                    bus.out_valid <= 1'b1;
                                    state         <= UNLOAD;
                                end else begin
                                    stage <= stage + 1'b1;
                                end
                            end else begin
                                bf <= bf + 1'b1;
                            end
                        end
                    endcase
                end
                default: begin
                    if (hs_out) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.tw_addr   = (state == CALC) ? tw_k : '0;
    assign bus.out_index = (state == UNLOAD) ? cnt : '0;
    assign bus.out_last  = bus.out_valid && (cnt == CNT_LAST);
    assign bus.out_re    = bus.out_valid ? mem_re[cnt] : '0;
    assign bus.out_im    = bus.out_valid ? mem_im[cnt] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_core_param
//  Brief    : Directed-vector bench for the 8-point fft_core_param.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_core_param;
    localparam int LOG2N = 3;
    localparam int DW    = 16;
    localparam int TW    = 16;
    localparam int N     = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   hs_cyc;
    int   xin_re [N];
    int   xin_im [N];
    int   res_re [N];
    int   res_im [N];

    // cos/sin(2*pi*k/8) in Q1.15
    logic signed [15:0] cos_tab [4] = '{16'sd32767, 16'sd23170, 16'sd0, -16'sd23170};
    logic signed [15:0] sin_tab [4] = '{16'sd0, 16'sd23170, 16'sd32767, 16'sd23170};
    int tw_exp [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_core_param_if #(.LOG2N(LOG2N), .DW(DW), .TW(TW)) bus ();

    fft_core_param #(.LOG2N(LOG2N), .DW(DW), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        bus.tw_cos <= cos_tab[bus.tw_addr];
        bus.tw_sin <= sin_tab[bus.tw_addr];
    end

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // scale_en is flipped after the first sample; only the first value may count.
    task automatic send_frame(input bit sc);
        int w;
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_re    = DW'(xin_re[n]);
            bus.in_im    = DW'(xin_im[n]);
            bus.scale_en = (n == 0) ? sc : ~sc;
            w = 0;
            while (!bus.in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!bus.in_ready) check("in_ready_timeout", 0, 1);
            hs_cyc = cyc;
        end
    endtask

    task automatic calc_phase();
        for (int t = 1; t <= 2 * N * LOG2N; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_re    = 16'sh1234;
            bus.in_im    = -16'sh0777;
            if (t == 1) begin
                check("calc_busy", bus.busy, 1);
                check("calc_in_ready", bus.in_ready, 0);
            end
            if ((t - 1) % 4 == 0)
                check($sformatf("tw_addr_bf%0d", (t - 1) / 4), bus.tw_addr, tw_exp[(t - 1) / 4]);
        end
    endtask

    task automatic collect(input bit rnd);
        int w, got;
        bit stalled;
        logic signed [DW-1:0] h_re, h_im;
        logic [LOG2N-1:0] h_idx;
        logic h_last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("first_out_latency", cyc - hs_cyc, 49);
        got = 0;
        stalled = 1'b0;
        w = 0;
        while (got < N && w < 400) begin
            if (bus.out_valid) begin
                if (stalled) begin
                    check("stall_re", bus.out_re, h_re);
                    check("stall_im", bus.out_im, h_im);
                    check("stall_index", bus.out_index, h_idx);
                    check("stall_last", bus.out_last, h_last);
                end
                bus.out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
                h_re = bus.out_re; h_im = bus.out_im; h_idx = bus.out_index; h_last = bus.out_last;
                if (bus.out_ready) begin
                    check($sformatf("out_index_%0d", got), bus.out_index, got);
                    check($sformatf("out_last_%0d", got), bus.out_last, (got == N - 1) ? 1 : 0);
                    res_re[got] = bus.out_re;
                    res_im[got] = bus.out_im;
                    got++;
                end
                stalled = !bus.out_ready;
            end
            @(negedge clk);
            w++;
        end
        check("unload_count", got, N);
        bus.out_ready = 1'b0;
        check("post_in_ready", bus.in_ready, 1);
        check("post_busy", bus.busy, 0);
        check("post_out_valid", bus.out_valid, 0);
    endtask

    task automatic run_frame(input bit sc, input bit rnd);
        send_frame(sc);
        calc_phase();
        collect(rnd);
    endtask

    task automatic set_impulse();
        for (int n = 0; n < N; n++) begin
            xin_re[n] = (n == 0) ? 1000 : 0;
            xin_im[n] = 0;
        end
    endtask

    task automatic check_impulse(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_re%0d", tag, k), res_re[k], 125);
            check($sformatf("%s_im%0d", tag, k), res_im[k], 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ov;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
        bus.scale_en = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tw_addr", bus.tw_addr, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_re", bus.out_re, 0);
        check("rst_out_im", bus.out_im, 0);
        rst = 1'b0;

        set_impulse();
        run_frame(1'b1, 1'b0);
        check_impulse("impulse");

        for (int n = 0; n < N; n++) begin xin_re[n] = 800; xin_im[n] = 0; end
        run_frame(1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("dc_re%0d", k), res_re[k], (k == 0) ? 800 : 0, 1);
            check($sformatf("dc_im%0d", k), res_im[k], 0, 1);
        end

        for (int n = 0; n < N; n++) begin xin_re[n] = (n % 2 == 0) ? 800 : -800; xin_im[n] = 0; end
        run_frame(1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("alt_re%0d", k), res_re[k], (k == 4) ? 800 : 0, 1);
            check($sformatf("alt_im%0d", k), res_im[k], 0, 1);
        end

        for (int n = 0; n < N; n++) begin xin_re[n] = 32767; xin_im[n] = 0; end
        run_frame(1'b0, 1'b0);
        check("sat_re0", res_re[0], 32767);
        check("sat_im0", res_im[0], 0, 2);
        for (int k = 1; k < N; k++) begin
            check($sformatf("sat_re%0d", k), res_re[k], 0, 2);
            check($sformatf("sat_im%0d", k), res_im[k], 0, 2);
        end

        set_impulse();
        run_frame(1'b1, 1'b1);
        check_impulse("stall");

        // Abort a frame mid-CALC; nothing from it may come out.
        for (int n = 0; n < N; n++) begin xin_re[n] = 800; xin_im[n] = 0; end
        send_frame(1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_tw_addr", bus.tw_addr, 0);
        ov = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.out_valid) ov++;
        end
        check("abort_no_output", ov, 0);

        set_impulse();
        run_frame(1'b1, 1'b0);
        check_impulse("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
